// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, MSB first, one bit per clock.
//
// Sends a default or loaded WIDTH-bit pattern. The pattern repeats repeat_n
// times (0 is treated as 1), with `gap` idle cycles between repetitions.
// Every output is registered and is valid one cycle after the deciding edge.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        begin a transmission (accepted in IDLE only)
//   use_default  1: send PATTERN, 0: send pattern_in (sampled with start)
//   pattern_in   user pattern, MSB first (sampled with start)
//   repeat_n     repetition count, 0 behaves as 1 (sampled with start)
//   gap          idle cycles between repetitions (sampled with start)
//   abort        cancel the current transmission without a done pulse
//   x_out        serial data line
//   valid        x_out carries a pattern bit this cycle
//   busy         high while sending or gapping
//   done         one-cycle pulse after the final bit
module seq_pattern_tx #(
   parameter int unsigned       WIDTH      = 4,
   parameter logic [WIDTH-1:0]  PATTERN    = 4'b1001,
   parameter int unsigned       CNT_W      = 4,
   parameter int unsigned       GAP_W      = 3,
   parameter logic              IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             use_default,
   input  logic [WIDTH-1:0] pattern_in,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             x_out,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] pat_q;     // pattern latched at start, reused for every repetition
   logic [WIDTH-1:0] shreg_q;   // bits still to send in the current repetition, MSB next
   logic [BW-1:0]    bit_cnt_q; // index of the bit currently on x_out
   logic [CNT_W-1:0] reps_q;    // repetitions left, including the current one
   logic [GAP_W-1:0] gap_len_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic [WIDTH-1:0] load_pat;

   assign load_pat = use_default ? PATTERN : pattern_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         pat_q     <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         reps_q    <= '0;
         gap_len_q <= '0;
         gap_cnt_q <= '0;
         x_out     <= IDLE_LEVEL;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // abort in the same cycle drops the start
               if (start && !abort) begin
                  pat_q     <= load_pat;
                  x_out     <= load_pat[WIDTH-1];
                  shreg_q   <= load_pat << 1;
                  bit_cnt_q <= BW'(WIDTH - 1);
                  reps_q    <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                  gap_len_q <= gap;
                  valid     <= 1'b1;
                  busy      <= 1'b1;
                  state_q   <= StSend;
               end
            end

            StSend: begin
               if (abort) begin
                  x_out   <= IDLE_LEVEL;
                  valid   <= 1'b0;
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end else if (bit_cnt_q != '0) begin
                  x_out     <= shreg_q[WIDTH-1];
                  shreg_q   <= shreg_q << 1;
                  bit_cnt_q <= bit_cnt_q - 1'b1;
               end else if (reps_q <= CNT_W'(1)) begin
                  // LSB of the final repetition was just on the line
                  reps_q  <= '0;
                  x_out   <= IDLE_LEVEL;
                  valid   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  reps_q <= reps_q - 1'b1;
                  if (gap_len_q == '0) begin
                     // back-to-back: next MSB follows with valid held high
                     x_out     <= pat_q[WIDTH-1];
                     shreg_q   <= pat_q << 1;
                     bit_cnt_q <= BW'(WIDTH - 1);
                  end else begin
                     gap_cnt_q <= gap_len_q;
                     x_out     <= IDLE_LEVEL;
                     valid     <= 1'b0;
                     state_q   <= StGap;
                  end
               end
            end

            StGap: begin
               if (abort) begin
                  x_out   <= IDLE_LEVEL;
                  valid   <= 1'b0;
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end else if (gap_cnt_q == GAP_W'(1)) begin
                  gap_cnt_q <= '0;
                  x_out     <= pat_q[WIDTH-1];
                  shreg_q   <= pat_q << 1;
                  bit_cnt_q <= BW'(WIDTH - 1);
                  valid     <= 1'b1;
                  state_q   <= StSend;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end

            StDone: begin
               // start and abort are both ignored here
               state_q <= StIdle;
            end

            default: begin
               x_out   <= IDLE_LEVEL;
               valid   <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
